// File: rtl/pattern_seq_pkg.sv
// Shared types and table-word field layout for the LED pattern sequencer.
package pattern_seq_pkg;

   typedef enum logic [2:0] {
      ST_CFG   = 3'd0,
      ST_FETCH = 3'd1,
      ST_WRITE = 3'd2,
      ST_HOLD  = 3'd3,
      ST_HALT  = 3'd4
   } state_e;

   localparam int LED_LSB  = 0;
   localparam int LED_W    = 8;
   localparam int HOLD_LSB = 8;
   localparam int HOLD_W   = 24;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [1:0] BTE_LINEAR  = 2'b00;

   function automatic logic [LED_W-1:0] led_of(input logic [31:0] word);
      return word[LED_LSB +: LED_W];
   endfunction

   function automatic logic [HOLD_W-1:0] hold_of(input logic [31:0] word);
      return word[HOLD_LSB +: HOLD_W];
   endfunction

endpackage

// File: rtl/pattern_seq_tick.sv
// Hold-time prescaler: tick_o pulses combinationally on every TICK_DIV-th enabled cycle.
// clr_i holds the count at zero; en_i low freezes it.
module pattern_seq_tick #(
   parameter int unsigned TICK_DIV = 1_000_000
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic tick_o
);

   localparam int unsigned   CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   assign tick_o = en_i & ~clr_i & (cnt_q == LAST);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/pattern_seq.sv
// Wishbone master playing a ROM pattern table onto GPIO; registered bus outputs, one idle cycle between cycles,
// rty reissues after one idle cycle. Optional bus watchdog enabled by defining PATTERN_SEQ_TIMEOUT_EN.
module pattern_seq
   import pattern_seq_pkg::*;
#(
   parameter logic [31:0] ROM_BASE     = 32'h0000_0000,
   parameter int unsigned ENTRIES      = 10,
   parameter logic [31:0] GPIO_DAT_ADR = 32'h9100_0000,
   parameter logic [31:0] GPIO_DIR_ADR = 32'h9100_0004,
   parameter logic [31:0] DIR_VALUE    = 32'h0000_00FF,
   parameter int unsigned TICK_DIV     = 1_000_000,
   parameter int unsigned TIMEOUT      = 255
) (
   input  logic                       wb_clk,
   input  logic                       wb_rst,
   input  logic                       en,
   output logic [31:0]                wb_adr_o,
   output logic [31:0]                wb_dat_o,
   output logic [3:0]                 wb_sel_o,
   output logic                       wb_we_o,
   output logic                       wb_cyc_o,
   output logic                       wb_stb_o,
   output logic [2:0]                 wb_cti_o,
   output logic [1:0]                 wb_bte_o,
   input  logic [31:0]                wb_dat_i,
   input  logic                       wb_ack_i,
   input  logic                       wb_err_i,
   input  logic                       wb_rty_i,
   output logic [$clog2(ENTRIES)-1:0] idx_o,
   output logic                       fault
);

   localparam int unsigned IDX_W = $clog2(ENTRIES);

   state_e             state_q;
   logic [IDX_W-1:0]   idx_q;
   logic               fault_q;
   logic [31:0]        word_q;
   logic [HOLD_W-1:0]  hold_q;

   logic               cyc_q;
   logic               we_q;
   logic [3:0]         sel_q;
   logic [31:0]        adr_q;
   logic [31:0]        dat_q;

   logic               tick;
   logic               tick_clr;
   logic               issue;
   logic               resp;
   logic               timeout;
   logic               done;
   logic [IDX_W-1:0]   idx_nxt;
   logic [31:0]        rom_off;
   logic [31:0]        adr_d;
   logic [31:0]        dat_d;
   logic               we_d;

   assign rom_off  = {{(30-IDX_W){1'b0}}, idx_q, 2'b00};
   assign idx_nxt  = (idx_q == IDX_W'(ENTRIES - 1)) ? '0 : idx_q + 1'b1;
   assign resp     = cyc_q & (wb_ack_i | wb_err_i | wb_rty_i);
   assign done     = resp | timeout;
   assign tick_clr = (state_q != ST_HOLD);

   // A new cycle only starts from an idle bus, so a completed cycle always leaves one idle cycle.
   always_comb begin
      issue = ~cyc_q & en & (state_q inside {ST_CFG, ST_FETCH, ST_WRITE});
      adr_d = GPIO_DIR_ADR;
      dat_d = DIR_VALUE;
      we_d  = 1'b1;
      case (state_q)
         ST_FETCH: begin
            adr_d = ROM_BASE + rom_off;
            dat_d = '0;
            we_d  = 1'b0;
         end
         ST_WRITE: begin
            adr_d = GPIO_DAT_ADR;
            dat_d = 32'(led_of(word_q));
         end
         default: ;
      endcase
   end

`ifdef PATTERN_SEQ_TIMEOUT_EN
   localparam int unsigned WDT_W = $clog2(TIMEOUT + 1);

   logic [WDT_W-1:0] wdt_q;

   assign timeout = cyc_q & ~(wb_ack_i | wb_err_i | wb_rty_i) & (wdt_q == WDT_W'(TIMEOUT - 1));

   always_ff @(posedge wb_clk) begin
      if (wb_rst || issue || resp) begin
         wdt_q <= '0;
      end else if (cyc_q) begin
         wdt_q <= wdt_q + 1'b1;
      end
   end
`else
   logic unused_timeout;

   assign timeout        = 1'b0;
   assign unused_timeout = ^TIMEOUT;
`endif

   pattern_seq_tick #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk_i  (wb_clk),
      .rst_i  (wb_rst),
      .clr_i  (tick_clr),
      .en_i   (en),
      .tick_o (tick)
   );

   always_ff @(posedge wb_clk) begin
      if (wb_rst || done) begin
         cyc_q <= 1'b0;
         we_q  <= 1'b0;
         sel_q <= 4'h0;
         adr_q <= '0;
         dat_q <= '0;
      end else if (issue) begin
         cyc_q <= 1'b1;
         we_q  <= we_d;
         sel_q <= 4'hF;
         adr_q <= adr_d;
         dat_q <= dat_d;
      end
   end

   // Response priority is err, then rty, then ack; rty leaves the state alone so the same cycle is reissued.
   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         state_q <= ST_CFG;
         idx_q   <= '0;
         fault_q <= 1'b0;
         word_q  <= '0;
         hold_q  <= '0;
      end else if (cyc_q) begin
         if (wb_err_i || timeout) begin
            fault_q <= 1'b1;
            state_q <= ST_HALT;
         end else if (wb_ack_i && !wb_rty_i) begin
            case (state_q)
               ST_CFG: begin
                  state_q <= ST_FETCH;
               end
               ST_FETCH: begin
                  word_q <= wb_dat_i;
                  if (hold_of(wb_dat_i) != '0) begin
                     state_q <= ST_WRITE;
                  end else if (idx_q != '0) begin
                     idx_q <= '0;
                  end else begin
                     fault_q <= 1'b1;
                     state_q <= ST_HALT;
                  end
               end
               ST_WRITE: begin
                  hold_q  <= hold_of(word_q);
                  state_q <= ST_HOLD;
               end
               default: ;
            endcase
         end
      end else if (state_q == ST_HOLD && tick) begin
         if (hold_q == HOLD_W'(1)) begin
            idx_q   <= idx_nxt;
            state_q <= ST_FETCH;
         end else begin
            hold_q <= hold_q - 1'b1;
         end
      end
   end

   assign wb_cyc_o = cyc_q;
   assign wb_stb_o = cyc_q;
   assign wb_we_o  = we_q;
   assign wb_sel_o = sel_q;
   assign wb_adr_o = adr_q;
   assign wb_dat_o = dat_q;
   assign wb_cti_o = CTI_CLASSIC;
   assign wb_bte_o = BTE_LINEAR;
   assign idx_o    = idx_q;
   assign fault    = fault_q;

endmodule

// File: doc/pattern_seq.md
# pattern_seq

Wishbone master that drives the LED pattern player. After reset it configures the GPIO direction register, then loops over a pattern table in ROM. Each table word holds an LED value and a hold time; the block writes the LED value to the GPIO data register and waits out the hold time. It is the only master on the plights bus, and the ROM and GPIO are its slaves.

## Interface
Parameters:
- ROM_BASE, 32'h0000_0000: byte address of pattern table entry 0.
- ENTRIES, 10: number of 32-bit table words (≥2).
- GPIO_DAT_ADR, 32'h9100_0000: GPIO data register byte address.
- GPIO_DIR_ADR, 32'h9100_0004: GPIO direction register byte address.
- DIR_VALUE, 32'h0000_00FF: value written to the direction register at start-up.
- TICK_DIV, 1_000_000: clock cycles per hold tick (≥1).
- TIMEOUT, 255: bus watchdog limit in cycles; used only with the macro below.

Ports (`wb_clk` is the single clock; `wb_rst` is a synchronous, active-high reset):
- wb_clk  in  1  clock
- wb_rst  in  1  synchronous active-high reset
- en  in  1  run enable
- wb_adr_o  out  32  byte address
- wb_dat_o  out  32  write data
- wb_sel_o  out  4  byte select, always 4'hF during a cycle
- wb_we_o  out  1  write enable
- wb_cyc_o  out  1  cycle
- wb_stb_o  out  1  strobe
- wb_cti_o  out  3  always 3'b000 (classic)
- wb_bte_o  out  2  always 2'b00
- wb_dat_i  in  32  read data
- wb_ack_i  in  1  acknowledge
- wb_err_i  in  1  error
- wb_rty_i  in  1  retry
- idx_o  out  $clog2(ENTRIES)  current table index
- fault  out  1  sticky fault flag

## Operation
Table word format:
- [7:0]: LED value.
- [31:8]: hold count H in ticks.
- H=0 marks end of list.

States and transitions:
- CFG: issue a write of DIR_VALUE to GPIO_DIR_ADR. On ack go to FETCH.
- FETCH: issue a read of ROM_BASE + 4*idx. On ack, latch the word.
  - If H≠0, go to WRITE.
  - If H=0 and idx≠0, set idx=0 and return to FETCH.
  - If H=0 and idx=0, set fault and go to HALT.
- WRITE: write {24'b0, word[7:0]} to GPIO_DAT_ADR. On ack, load hold counter with H and go to HOLD.
- HOLD: decrement the counter on each tick. When it reaches 0:
  - idx = (idx == ENTRIES-1) ? 0 : idx+1;
  - go to FETCH.
- HALT: terminal state; only `wb_rst` leaves it.

Bus responses:
- ack: completes the transaction.
- rty: drop cyc/stb for 1 cycle, then reissue the identical transaction. There is no retry limit.
- err: set fault, go to HALT, and do not update idx.
- Simultaneous ack and err/rty: err takes priority, then rty, then ack.

Enable behaviour:
- en=0 never aborts an active bus cycle.
- The FSM does not start a new transaction while en=0.
- In HOLD, tick counting freezes while en=0.

Reset values:
- All bus outputs are 0. wb_sel_o = 0 outside a cycle.
- idx_o = 0, fault = 0, state = CFG, prescaler = 0.
- Reset mid-cycle drops cyc/stb on the next edge, with no completion.

## Timing
- cyc/stb/we/adr/dat are registered. They assert the cycle after the state is entered and stay stable until the terminating response.
- cyc/stb deassert the cycle after ack. The next transaction starts at the earliest 1 cycle later, so there is no back-to-back strobe.
- The prescaler restarts at 0 on entry to HOLD.
- LED hold lasts exactly H*TICK_DIV cycles with en=1, measured from the cycle after the WRITE ack to the first FETCH cycle.
- idx_o updates on the same edge HOLD exits.

## Configuration
- `PATTERN_SEQ_TIMEOUT_EN` defined: a watchdog counts cycles with cyc high and no ack/err/rty.
  - At TIMEOUT it drops cyc/stb, sets fault, and enters HALT.
  - The counter clears on every response and on every new cycle.
- Macro undefined: no watchdog logic; the block waits indefinitely for a response.

## Structure
- pattern_seq_pkg holds:
  - state enum (CFG, FETCH, WRITE, HOLD, HALT);
  - field constants LED_LSB=0, LED_W=8, HOLD_LSB=8, HOLD_W=24;
  - CTI_CLASSIC, BTE_LINEAR.
- One sub-module, pattern_seq_tick: prescaler with clear and enable inputs that emits a 1-cycle tick every TICK_DIV enabled cycles.

## Test plan
- Reset release; ROM = {0x000001_AA, 0x000002_55, 0}; ENTRIES=3; TICK_DIV=4.
  - First transaction writes 0xFF to DIR.
  - Then a GPIO write of 0xAA, a 4-cycle hold, a write of 0x55, and an 8-cycle hold.
  - The H=0 entry wraps the sequence back to 0xAA.
- Slave returns rty once on a FETCH → cyc low 1 cycle, then the same address is reissued; sequence unaffected.
- Slave returns err on a WRITE → fault=1, FSM in HALT, no further cyc; wb_rst clears fault and restarts at CFG.
- en=0 asserted mid-HOLD for 10 cycles → hold extended by exactly 10 cycles; en=0 during an active cycle does not drop cyc.
- Entry 0 with H=0 → fault=1 after the first fetch, and no GPIO data write occurs.
- With `PATTERN_SEQ_TIMEOUT_EN` and TIMEOUT=8, a slave that never responds → cyc drops after 8 cycles and fault=1.
